// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencing controller: stall encodings,
// FSM state type and default addresses/codes.
package pipe_ctrl_pkg;

    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [5:0] StallId   = 6'b000111;
    localparam logic [5:0] StallEx   = 6'b001111;
    localparam logic [5:0] StallMem  = 6'b011111;
    localparam logic [5:0] StallAll  = 6'b111111;

    localparam logic [31:0] DefExcVector = 32'h0000_0020;
    localparam logic [31:0] DefHaltCode  = 32'h0000_00ff;
    localparam logic [31:0] DefEretCode  = 32'h0000_000e;
    localparam int          DefBusTimeout = 64;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side signal bundle of the sequencing controller: stall/exception/branch
// requests towards the controller and stall/flush/redirect controls back.
interface pipe_ctrl_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] epc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        resume_i;
    logic [5:0]  stall;
    logic        flush;
    logic        redirect;
    logic [31:0] new_pc;
    logic        timeout_o;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, epc_i,
               branch_flag_i, branch_target_i, resume_i,
        input  stall, flush, redirect, new_pc, timeout_o
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, epc_i,
               branch_flag_i, branch_target_i, resume_i,
        output stall, flush, redirect, new_pc, timeout_o
    );
endinterface

// File: rtl/bus_watchdog.sv
// Counts consecutive MEM bus-wait cycles; expire fires on the BUS_TIMEOUT-th one.
module bus_watchdog #(
    parameter int BUS_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);
    localparam logic [7:0] LastCount = 8'(BUS_TIMEOUT - 1);

    logic [7:0] count_reg;

    assign expire = en && (count_reg == LastCount);

    // clr has priority so an expiry (which also flushes) restarts from zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= 8'd0;
        end else if (clr) begin
            count_reg <= 8'd0;
        end else if (en) begin
            count_reg <= count_reg + 8'd1;
        end
    end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stage stall requests, raises flush/redirect
// on exceptions, ERET, branches and bus timeouts, and runs the RUN/HALT machine.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = DefExcVector,
    parameter logic [31:0] HALT_CODE   = DefHaltCode,
    parameter logic [31:0] ERET_CODE   = DefEretCode,
    parameter int          BUS_TIMEOUT = DefBusTimeout
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.slave    bus
);
    state_t      state_reg, state_next;
    logic        timeout_reg, timeout_next;
    logic [5:0]  stall_next;
    logic        flush_next;
    logic        redirect_next;
    logic [31:0] pc_next;
    logic        wd_en, wd_clr, wd_expire;

    wire in_run = (state_reg == RUN);

    // Watchdog is frozen in HALT; any flush in RUN restarts the bus-wait count
    assign wd_en  = rst && in_run && bus.stallreq_mem;
    assign wd_clr = in_run && (!bus.stallreq_mem || flush_next);

    bus_watchdog #(.BUS_TIMEOUT(BUS_TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .en     (wd_en),
        .clr    (wd_clr),
        .expire (wd_expire)
    );

    always_comb begin
        stall_next    = StallNone;
        flush_next    = 1'b0;
        redirect_next = 1'b0;
        pc_next       = 32'd0;
        state_next    = state_reg;
        timeout_next  = timeout_reg;
        if (rst) begin
            unique case (state_reg)
                RUN: begin
                    if (wd_expire) begin
                        flush_next    = 1'b1;
                        redirect_next = 1'b1;
                        pc_next       = EXC_VECTOR;
                        timeout_next  = 1'b1;
                    end else if (bus.excepttype_i != 32'd0) begin
                        flush_next    = 1'b1;
                        redirect_next = 1'b1;
                        pc_next       = (bus.excepttype_i == ERET_CODE) ? bus.epc_i : EXC_VECTOR;
                        if (bus.excepttype_i == HALT_CODE) begin
                            state_next = HALT;
                        end
                    end else if (bus.stallreq_mem) begin
                        stall_next = StallMem;
                    end else if (bus.stallreq_ex) begin
                        stall_next = StallEx;
                    end else if (bus.stallreq_id) begin
                        stall_next = StallId;
                    end else if (bus.branch_flag_i) begin
                        redirect_next = 1'b1;
                        pc_next       = bus.branch_target_i;
                    end
                end
                HALT: begin
                    stall_next = StallAll;
                    if (bus.resume_i) begin
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= RUN;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timeout_reg <= timeout_next;
        end
    end

    assign bus.stall     = stall_next;
    assign bus.flush     = flush_next;
    assign bus.redirect  = redirect_next;
    assign bus.new_pc    = pc_next;
    assign bus.timeout_o = timeout_reg;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the controller rules.
module tb_pipe_ctrl;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if bus();

    pipe_ctrl #(
        .EXC_VECTOR  (32'h0000_0020),
        .HALT_CODE   (32'h0000_00ff),
        .ERET_CODE   (32'h0000_000e),
        .BUS_TIMEOUT (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state: halted flag, length of the current bus-wait run, sticky timeout
    bit m_halted = 0, n_halted = 0;
    int m_run = 0, n_run = 0;
    bit m_tmo = 0, n_tmo = 0;

    logic [5:0]  e_stall;
    logic        e_flush, e_redirect, e_tmo;
    logic [31:0] e_pc;
    bit          cmp_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic eval();
        bit expiry;
        e_stall = 6'h00; e_flush = 0; e_redirect = 0; e_pc = 32'h0; e_tmo = 0;
        if (!rst) begin
            n_halted = 0; n_run = 0; n_tmo = 0;
            return;
        end
        e_tmo = m_tmo;
        n_halted = m_halted; n_run = m_run; n_tmo = m_tmo;
        if (m_halted) begin
            e_stall = 6'h3f;
            if (bus.resume_i) n_halted = 0;
        end else begin
            expiry = bus.stallreq_mem && (m_run == TMO - 1);
            if (expiry) begin
                e_flush = 1; e_redirect = 1; e_pc = 32'h20;
                n_tmo = 1; n_run = 0;
            end else if (bus.excepttype_i != 0) begin
                e_flush = 1; e_redirect = 1;
                e_pc = (bus.excepttype_i == 32'h0e) ? bus.epc_i : 32'h20;
                n_halted = (bus.excepttype_i == 32'hff);
                n_run = 0;
            end else begin
                n_run = bus.stallreq_mem ? m_run + 1 : 0;
                if (bus.stallreq_mem)       e_stall = 6'h1f;
                else if (bus.stallreq_ex)   e_stall = 6'h0f;
                else if (bus.stallreq_id)   e_stall = 6'h07;
                else if (bus.branch_flag_i) begin
                    e_redirect = 1; e_pc = bus.branch_target_i;
                end
            end
        end
    endtask

    task automatic cycle(input bit id, input bit ex, input bit mem, input logic [31:0] exc,
                         input logic [31:0] epc, input bit br, input logic [31:0] tgt,
                         input bit res, input bit r);
        @(posedge clk);
        m_halted = n_halted; m_run = n_run; m_tmo = n_tmo;
        #1;
        cyc++;
        rst = r;
        bus.stallreq_id = id; bus.stallreq_ex = ex; bus.stallreq_mem = mem;
        bus.excepttype_i = exc; bus.epc_i = epc;
        bus.branch_flag_i = br; bus.branch_target_i = tgt; bus.resume_i = res;
        eval();
        cmp_en = 1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 1);
    endtask

    // single compare process against the model, once per cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            check("stall", 32'(bus.stall), 32'(e_stall));
            check("flush", 32'(bus.flush), 32'(e_flush));
            check("redirect", 32'(bus.redirect), 32'(e_redirect));
            check("new_pc", bus.new_pc, e_pc);
            check("timeout_o", 32'(bus.timeout_o), 32'(e_tmo));
            $display("cycle %0d rst=%0b stall=%h flush=%0b redirect=%0b new_pc=%h timeout=%0b",
                     cyc, rst, bus.stall, bus.flush, bus.redirect, bus.new_pc, bus.timeout_o);
        end
    end

    initial begin
        int burst;
        bit mem;
        logic [31:0] exc;
        bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.stallreq_mem = 0;
        bus.excepttype_i = 0; bus.epc_i = 0; bus.branch_flag_i = 0;
        bus.branch_target_i = 0; bus.resume_i = 0;

        // reset held with requests present: everything stays 0
        cycle(1, 1, 1, 32'h0e, 32'h44, 1, 32'h88, 0, 0);
        @(negedge clk);
        check("lit_reset_stall", 32'(bus.stall), 32'h0);
        check("lit_reset_tmo", 32'(bus.timeout_o), 32'h0);
        idle();

        // EX+ID stall for 3 cycles
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 32'h0, 32'h0, 0, 32'h0, 0, 1);
            @(negedge clk);
            check("lit_ex_stall", 32'(bus.stall), 32'h0f);
            check("lit_ex_redirect", 32'(bus.redirect), 32'h0);
        end
        idle();
        @(negedge clk);
        check("lit_ex_release", 32'(bus.stall), 32'h0);

        // taken branch
        cycle(0, 0, 0, 32'h0, 32'h0, 1, 32'h1000, 0, 1);
        @(negedge clk);
        check("lit_br_redirect", 32'(bus.redirect), 32'h1);
        check("lit_br_pc", bus.new_pc, 32'h1000);
        check("lit_br_flush", 32'(bus.flush), 32'h0);

        // ERET together with a branch
        cycle(0, 0, 0, 32'h0e, 32'h400, 1, 32'h1000, 0, 1);
        @(negedge clk);
        check("lit_eret_flush", 32'(bus.flush), 32'h1);
        check("lit_eret_pc", bus.new_pc, 32'h400);

        // 63-cycle bus wait: no expiry
        for (int i = 0; i < TMO - 1; i++) cycle(0, 0, 1, 32'h0, 32'h0, 0, 32'h0, 0, 1);
        @(negedge clk);
        check("lit_burst63_stall", 32'(bus.stall), 32'h1f);
        check("lit_burst63_flush", 32'(bus.flush), 32'h0);
        idle();

        // 64-cycle bus wait: expiry on the last cycle
        for (int i = 0; i < TMO; i++) cycle(0, 0, 1, 32'h0, 32'h0, 0, 32'h0, 0, 1);
        @(negedge clk);
        check("lit_expire_flush", 32'(bus.flush), 32'h1);
        check("lit_expire_pc", bus.new_pc, 32'h20);
        check("lit_expire_stall", 32'(bus.stall), 32'h0);
        idle();
        @(negedge clk);
        check("lit_timeout_set", 32'(bus.timeout_o), 32'h1);

        // HALT entry, requests ignored, resume
        cycle(0, 0, 0, 32'hff, 32'h0, 0, 32'h0, 0, 1);
        @(negedge clk);
        check("lit_halt_pc", bus.new_pc, 32'h20);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 1, 32'h0e, 32'h400, 1, 32'h0, 0, 1);
            @(negedge clk);
            check("lit_halt_stall", 32'(bus.stall), 32'h3f);
            check("lit_halt_flush", 32'(bus.flush), 32'h0);
        end
        cycle(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 1);
        @(negedge clk);
        check("lit_resume_cycle", 32'(bus.stall), 32'h3f);
        idle();
        @(negedge clk);
        check("lit_after_resume", 32'(bus.stall), 32'h0);

        // asynchronous reset in HALT with timeout set
        cycle(0, 0, 0, 32'hff, 32'h0, 0, 32'h0, 0, 1);
        idle();
        @(posedge clk);
        m_halted = n_halted; m_run = n_run; m_tmo = n_tmo;
        #3;
        rst = 0;
        eval();
        #1;
        check("lit_async_stall", 32'(bus.stall), 32'h0);
        check("lit_async_tmo", 32'(bus.timeout_o), 32'h0);
        cycle(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0);
        idle();
        @(negedge clk);
        check("lit_post_reset_tmo", 32'(bus.timeout_o), 32'h0);
        cycle(0, 0, 1, 32'h0, 32'h0, 0, 32'h0, 0, 1);
        @(negedge clk);
        check("lit_post_reset_run", 32'(bus.stall), 32'h1f);

        // randomized traffic
        burst = 0;
        for (int i = 0; i < 450; i++) begin
            if (burst == 0 && $urandom_range(0, 5) == 0) burst = $urandom_range(1, 80);
            mem = (burst > 0);
            if (burst > 0) burst--;
            exc = 32'h0;
            if ($urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 2))
                    0: exc = 32'h0e;
                    1: exc = 32'hff;
                    default: exc = $urandom | 32'h100;
                endcase
            end
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, mem, exc, $urandom,
                  $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 199) != 0);
        end
        @(negedge clk);
        cmp_en = 0;
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
